bp_update_scheduler: RTL
========================

// Module: bp_update_scheduler
// PURPOSE
//   Serialises branch-resolution training updates from two requesters into the
//   predictor's single update port (transition_signal/transition_addr/branch).
//   - Round-robin arbitration between the two requesters.
//   - Accepted requests are buffered in a DEPTH-entry FIFO.
//   - Drains one update per cycle unless held.
//   - Keeps a saturating count of accepted mispredictions.
// PARAMETERS
//   LOCAL_WIDTH  6   width of predictor index (matches predictor LOCAL_WIDTH)
//   DEPTH        4   FIFO entries; power of two, >= 2
//   CNT_WIDTH    16  width of mispredict counter
// PORTS
//   clk_in           in   1            system clock
//   rst_in           in   1            synchronous, active-high reset
//   clear_in         in   1            discard all buffered updates
//   hold_in          in   1            1 = do not issue an update this cycle
//   req0_valid       in   1            requester 0 has a resolved branch
//   req0_addr        in   LOCAL_WIDTH  predictor index of that branch
//   req0_branch      in   1            1 = taken, 0 = not taken
//   req0_mispredict  in   1            1 = prediction was wrong
//   req0_ready       out  1            request 0 accepted this cycle
//   req1_*           --   --           same four inputs and ready output for requester 1
//   upd_valid        out  1            drives predictor transition_signal
//   upd_addr         out  LOCAL_WIDTH  drives predictor transition_addr
//   upd_branch       out  1            drives predictor branch
//   empty            out  1            FIFO count == 0
//   full             out  1            FIFO count == DEPTH
//   mispredict_cnt   out  CNT_WIDTH    saturating count of accepted mispredicts
// BEHAVIOUR
//   Reset (rst_in=1 at posedge)
//   - count, head, tail -> 0; rr_ptr -> 0 (requester 0 favoured); mispredict_cnt -> 0.
//   - Hence empty=1, full=0, upd_valid=0, req*_ready=0 while no valid.
//   Arbitration (combinational)
//   - Candidates are requesters with valid=1; grant at most one per cycle.
//   - Both valid: grant rr_ptr. Only one valid: grant it.
//   - reqN_ready = grantN & ~full & ~clear_in & ~rst_in. ready may depend on valid.
//   - Accept = reqN_valid & reqN_ready. On accept, rr_ptr <= ~N at the edge.
//   - With no accept, rr_ptr holds.
//   FIFO
//   - Push on accept: entry {addr, branch} written at tail; tail wraps modulo DEPTH.
//   - Issue (combinational): upd_valid = ~empty & ~hold_in & ~clear_in.
//     upd_addr/upd_branch = head entry; they are 0 when empty.
//   - Pop whenever upd_valid=1; head wraps modulo DEPTH.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - full blocks push even if a pop happens that cycle (no same-cycle bypass).
//   - Minimum latency: request accepted at edge k -> upd_valid in the cycle after edge k.
//   - Order of updates equals order of acceptance.
//   clear_in (priority below rst_in)
//   - count, head, tail -> 0; no accept and no issue that cycle.
//   - rr_ptr and mispredict_cnt unaffected.
//   Mispredict counter
//   - +1 on each accepted request with mispredict=1.
//   - Saturates at 2^CNT_WIDTH-1 and never wraps.
//   - Cleared only by rst_in.
//   Other rules
//   - hold_in only stalls issue; pushes continue until full.
//   - Reset mid-operation drops all buffered updates and any request presented that cycle.
// TESTING
//   1. Single req0 {addr=5,branch=1} at cycle 1
//      -> req0_ready=1 in cycle 1; upd_valid=1, upd_addr=5, upd_branch=1 in cycle 2; empty=1 after.
//   2. Both requesters valid for 4 cycles, addrs 0/1, after reset
//      -> grants alternate 0,1,0,1; updates issue in the same order.
//   3. hold_in=1, req0 valid 6 cycles
//      -> 4 accepts, then full=1 and req0_ready=0.
//      -> Drop hold: 4 updates on consecutive cycles, FIFO order.
//   4. FIFO at count=2, push and pop same cycle
//      -> count stays 2; pointers wrap correctly across 3+ full cycles.
//   5. FIFO holds 3 entries, assert clear_in one cycle
//      -> empty=1 next cycle; upd_valid=0 during clear; mispredict_cnt unchanged.
//   6. CNT_WIDTH=4, 17 accepted mispredicts
//      -> mispredict_cnt = 15 and holds; rst_in -> 0.

Source files
------------

// File: rtl/bp_update_scheduler.sv
// Round-robin merge of two branch-resolution requesters into the predictor's single
// training port, buffered through a small FIFO, with a saturating mispredict count.
module bp_update_scheduler #(
    parameter int LOCAL_WIDTH = 6,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   clear_in,
    input  logic                   hold_in,
    input  logic                   req0_valid,
    input  logic [LOCAL_WIDTH-1:0] req0_addr,
    input  logic                   req0_branch,
    input  logic                   req0_mispredict,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [LOCAL_WIDTH-1:0] req1_addr,
    input  logic                   req1_branch,
    input  logic                   req1_mispredict,
    output logic                   req1_ready,
    output logic                   upd_valid,
    output logic [LOCAL_WIDTH-1:0] upd_addr,
    output logic                   upd_branch,
    output logic                   empty,
    output logic                   full,
    output logic [CNT_WIDTH-1:0]   mispredict_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [LOCAL_WIDTH:0] mem [DEPTH];
    logic [PW:0]          count;
    logic [PW-1:0]        head, tail;
    logic                 rr_ptr;

    logic grant0, grant1, acc0, acc1, push, pop, push_misp;
    logic [LOCAL_WIDTH:0] push_data;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // rr_ptr names the requester that wins when both are valid
    assign grant0 = req0_valid & (~req1_valid | ~rr_ptr);
    assign grant1 = req1_valid & (~req0_valid |  rr_ptr);

    assign req0_ready = grant0 & ~full & ~clear_in & ~rst_in;
    assign req1_ready = grant1 & ~full & ~clear_in & ~rst_in;
    assign acc0 = req0_valid & req0_ready;
    assign acc1 = req1_valid & req1_ready;
    assign push = acc0 | acc1;

    assign push_data = acc1 ? {req1_addr, req1_branch} : {req0_addr, req0_branch};
    assign push_misp = acc1 ? req1_mispredict : (acc0 & req0_mispredict);

    assign upd_valid  = ~empty & ~hold_in & ~clear_in;
    assign pop        = upd_valid;
    assign upd_addr   = empty ? '0   : mem[head][LOCAL_WIDTH:1];
    assign upd_branch = empty ? 1'b0 : mem[head][0];

    always_ff @(posedge clk_in) begin
        if (push)
            mem[tail] <= push_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (clear_in) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr <= 1'b0;
        end else if (acc0) begin
            rr_ptr <= 1'b1;
        end else if (acc1) begin
            rr_ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mispredict_cnt <= '0;
        end else if (push_misp && mispredict_cnt != CNT_MAX) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end
endmodule
